// File: rtl/pc_fetch_unit.sv
// ---------------------------------------------------------------------------
// pc_fetch_unit
//   Per-thread program counter and instruction fetcher. It issues valid/ready
//   read requests to program memory and holds each fetched instruction until
//   the sequencer advances it. It then picks the next PC: sequential, taken
//   BRnzp target, or stop on RET.
//
// Parameters
//   PM_ADDR_BITS : program memory address width (also the PC width)
//   PM_DATA_BITS : instruction width (opcode is taken from bits [15:12])
//   START_PC     : PC loaded when Start is accepted
//
// Ports
//   CLK          in   clock, rising edge
//   RST          in   asynchronous active-high reset
//   Start        in   begin at START_PC (accepted in IDLE/DONE)
//   Advance      in   held instruction consumed (accepted in HOLD)
//   NZPIn        in   stored {N,Z,P} flags, sampled in the Advance cycle
//   MemReadValid out  program memory read request (state FETCH)
//   MemReadAddr  out  request address, always equal to PCOut
//   MemReadReady in   memory response, data valid in the same cycle
//   MemReadData  in   instruction word
//   Instr        out  held instruction
//   InstrValid   out  Instr valid (state HOLD)
//   PCOut        out  current PC
//   Done         out  thread executed RET (state DONE)
// ---------------------------------------------------------------------------
module pc_fetch_unit #(
    parameter int                        PM_ADDR_BITS = 8,
    parameter int                        PM_DATA_BITS = 16,
    parameter logic [PM_ADDR_BITS-1:0]   START_PC     = '0
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    Start,
    input  logic                    Advance,
    input  logic [2:0]              NZPIn,
    output logic                    MemReadValid,
    output logic [PM_ADDR_BITS-1:0] MemReadAddr,
    input  logic                    MemReadReady,
    input  logic [PM_DATA_BITS-1:0] MemReadData,
    output logic [PM_DATA_BITS-1:0] Instr,
    output logic                    InstrValid,
    output logic [PM_ADDR_BITS-1:0] PCOut,
    output logic                    Done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [3:0] OP_BR  = 4'b0001;
    localparam logic [3:0] OP_RET = 4'b1111;

    state_t                  r_state;
    logic [PM_ADDR_BITS-1:0] r_pc;
    logic [PM_DATA_BITS-1:0] r_instr;

    logic [3:0] w_opcode;
    logic       w_taken;

    assign w_opcode = r_instr[15:12];
    // Flags are one-hot in practice, so any overlap with the mask means taken.
    assign w_taken  = (r_instr[11:9] & NZPIn) != 3'b000;

    // Sequential successor, wraps modulo 2^PM_ADDR_BITS.
    function automatic logic [PM_ADDR_BITS-1:0] pc_inc(input logic [PM_ADDR_BITS-1:0] pc);
        return pc + PM_ADDR_BITS'(1);
    endfunction

    // 8-bit branch target zero-extended or truncated to the PC width.
    function automatic logic [PM_ADDR_BITS-1:0] br_target(input logic [7:0] tgt);
        logic [PM_ADDR_BITS+7:0] ext;
        ext = {{PM_ADDR_BITS{1'b0}}, tgt};
        return ext[PM_ADDR_BITS-1:0];
    endfunction

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_pc    <= '0;
            r_instr <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (Start) begin
                        r_pc    <= START_PC;
                        r_state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (MemReadReady) begin
                        r_instr <= MemReadData;
                        r_state <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (Advance) begin
                        if (w_opcode == OP_RET) begin
                            r_state <= S_DONE;
                        end else begin
                            if (w_opcode == OP_BR && w_taken)
                                r_pc <= br_target(r_instr[7:0]);
                            else
                                r_pc <= pc_inc(r_pc);
                            r_state <= S_FETCH;
                        end
                    end
                end
                S_DONE: begin
                    if (Start) begin
                        r_pc    <= START_PC;
                        r_state <= S_FETCH;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Outputs come straight from state/registers, so there is no input-to-output path.
    assign MemReadValid = (r_state == S_FETCH);
    assign MemReadAddr  = r_pc;
    assign PCOut        = r_pc;
    assign Instr        = r_instr;
    assign InstrValid   = (r_state == S_HOLD);
    assign Done         = (r_state == S_DONE);

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

    localparam logic [7:0] START = 8'h00;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        Start = 1'b0;
    logic        Advance = 1'b0;
    logic [2:0]  NZPIn = 3'b000;
    logic        MemReadReady = 1'b0;
    logic [15:0] MemReadData = 16'h0000;
    logic        MemReadValid;
    logic [7:0]  MemReadAddr;
    logic [15:0] Instr;
    logic        InstrValid;
    logic [7:0]  PCOut;
    logic        Done;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: where the program counter should be and what
    // instruction the unit should be holding.
    logic [7:0]  m_pc;
    logic [15:0] m_instr;

    pc_fetch_unit #(
        .PM_ADDR_BITS(8),
        .PM_DATA_BITS(16),
        .START_PC(START)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .Start(Start),
        .Advance(Advance),
        .NZPIn(NZPIn),
        .MemReadValid(MemReadValid),
        .MemReadAddr(MemReadAddr),
        .MemReadReady(MemReadReady),
        .MemReadData(MemReadData),
        .Instr(Instr),
        .InstrValid(InstrValid),
        .PCOut(PCOut),
        .Done(Done)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic is_ret(input logic [15:0] w);
        return w[15:12] == 4'hF;
    endfunction

    // Next PC from the architectural rules.
    function automatic logic [7:0] model_next(input logic [7:0] pc, input logic [15:0] w,
                                              input logic [2:0] nzp);
        int mask_hits;
        mask_hits = 0;
        for (int b = 0; b < 3; b++) if (w[9+b] && nzp[b]) mask_hits++;
        if (w[15:12] == 4'h1 && mask_hits > 0) return w[7:0];
        return 8'((int'(pc) + 1) % 256);
    endfunction

    // From FETCH: stall `stall` cycles with Ready low, then deliver word w.
    task automatic fetch_word(input logic [15:0] w, input int stall, input string tag);
        for (int i = 0; i < stall; i++) begin
            Start   = 1'($urandom);
            Advance = 1'($urandom);
            tick();
            n_checks++;
            if (MemReadValid !== 1'b1 || MemReadAddr !== m_pc || InstrValid !== 1'b0) begin
                n_fail++;
                $display("FAIL %s_stall cyc%0d: valid=%b addr=%h ivalid=%b, want valid=1 addr=%h ivalid=0",
                         tag, i, MemReadValid, MemReadAddr, InstrValid, m_pc);
            end
        end
        Start        = 1'b0;
        Advance      = 1'b0;
        MemReadReady = 1'b1;
        MemReadData  = w;
        tick();
        MemReadReady = 1'b0;
        MemReadData  = 16'($urandom);
        m_instr      = w;
        n_checks++;
        if (Instr !== w || InstrValid !== 1'b1 || MemReadValid !== 1'b0 || PCOut !== m_pc) begin
            n_fail++;
            $display("FAIL %s_fetch: instr=%h ivalid=%b mvalid=%b pc=%h, want instr=%h ivalid=1 mvalid=0 pc=%h",
                     tag, Instr, InstrValid, MemReadValid, PCOut, w, m_pc);
        end
    endtask

    // From HOLD: wait `hold` cycles with spurious Start/Ready, then Advance.
    task automatic advance_instr(input logic [2:0] nzp, input int hold, input string tag);
        for (int i = 0; i < hold; i++) begin
            Start        = 1'($urandom);
            MemReadReady = 1'($urandom);
            MemReadData  = 16'($urandom);
            tick();
            n_checks++;
            if (Instr !== m_instr || InstrValid !== 1'b1 || PCOut !== m_pc) begin
                n_fail++;
                $display("FAIL %s_hold cyc%0d: instr=%h ivalid=%b pc=%h, want instr=%h ivalid=1 pc=%h",
                         tag, i, Instr, InstrValid, PCOut, m_instr, m_pc);
            end
        end
        Start        = 1'b0;
        MemReadReady = 1'b0;
        Advance      = 1'b1;
        NZPIn        = nzp;
        tick();
        Advance = 1'b0;
        NZPIn   = 3'($urandom);
        n_checks++;
        if (is_ret(m_instr)) begin
            if (Done !== 1'b1 || MemReadValid !== 1'b0 || InstrValid !== 1'b0 || PCOut !== m_pc) begin
                n_fail++;
                $display("FAIL %s_ret: done=%b mvalid=%b ivalid=%b pc=%h, want done=1 mvalid=0 ivalid=0 pc=%h",
                         tag, Done, MemReadValid, InstrValid, PCOut, m_pc);
            end
        end else begin
            m_pc = model_next(m_pc, m_instr, nzp);
            if (PCOut !== m_pc || MemReadAddr !== m_pc || MemReadValid !== 1'b1 || InstrValid !== 1'b0) begin
                n_fail++;
                $display("FAIL %s_next: pc=%h addr=%h mvalid=%b ivalid=%b, want pc=%h addr=%h mvalid=1 ivalid=0",
                         tag, PCOut, MemReadAddr, MemReadValid, InstrValid, m_pc, m_pc);
            end
        end
    endtask

    // From DONE: restart, with a simultaneous Advance that must be ignored.
    task automatic restart(input string tag);
        Start   = 1'b1;
        Advance = 1'b1;
        tick();
        Start   = 1'b0;
        Advance = 1'b0;
        m_pc    = START;
        n_checks++;
        if (Done !== 1'b0 || PCOut !== START || MemReadValid !== 1'b1 || MemReadAddr !== START) begin
            n_fail++;
            $display("FAIL %s_restart: done=%b pc=%h mvalid=%b addr=%h, want done=0 pc=%h mvalid=1 addr=%h",
                     tag, Done, PCOut, MemReadValid, MemReadAddr, START, START);
        end
    endtask

    function automatic logic [2:0] onehot_nzp();
        return 3'(1 << $urandom_range(0, 2));
    endfunction

    task automatic test_reset();
        #2;
        n_checks++;
        if (PCOut !== 8'h00 || Instr !== 16'h0 || MemReadValid !== 1'b0 || InstrValid !== 1'b0 || Done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: pc=%h instr=%h mvalid=%b ivalid=%b done=%b, want all zero",
                     PCOut, Instr, MemReadValid, InstrValid, Done);
        end
        tick();
        RST = 1'b0;
        // Ready and Advance in IDLE must not move anything.
        MemReadReady = 1'b1;
        MemReadData  = 16'hBEEF;
        Advance      = 1'b1;
        tick();
        MemReadReady = 1'b0;
        Advance      = 1'b0;
        n_checks++;
        if (Instr !== 16'h0 || MemReadValid !== 1'b0 || InstrValid !== 1'b0 || PCOut !== 8'h00) begin
            n_fail++;
            $display("FAIL idle_ignore: instr=%h mvalid=%b ivalid=%b pc=%h, want 0000/0/0/00",
                     Instr, MemReadValid, InstrValid, PCOut);
        end
    endtask

    task automatic test_basic_fetch();
        Start = 1'b1;
        tick();
        Start = 1'b0;
        m_pc  = START;
        n_checks++;
        if (MemReadValid !== 1'b1 || MemReadAddr !== 8'h00) begin
            n_fail++;
            $display("FAIL start_fetch: mvalid=%b addr=%h, want mvalid=1 addr=00", MemReadValid, MemReadAddr);
        end
        fetch_word(16'h3000, 1, "basic");
        advance_instr(onehot_nzp(), 0, "basic");
    endtask

    task automatic test_branch_taken();
        fetch_word(16'h1A14, 0, "br_taken");
        advance_instr(3'b100, 0, "br_taken");
        n_checks++;
        if (PCOut !== 8'h14) begin
            n_fail++;
            $display("FAIL br_taken_pc: pc=%h, want 14", PCOut);
        end
    endtask

    task automatic test_branch_not_taken();
        fetch_word(16'h1E05, 0, "br_to5");
        advance_instr(3'b001, 0, "br_to5");
        fetch_word(16'h1A14, 0, "br_nt");
        advance_instr(3'b010, 0, "br_nt");
        n_checks++;
        if (PCOut !== 8'h06) begin
            n_fail++;
            $display("FAIL br_nt_pc: pc=%h, want 06", PCOut);
        end
        fetch_word(16'h1014, 0, "br_mask0");
        advance_instr(onehot_nzp(), 0, "br_mask0");
        n_checks++;
        if (PCOut !== 8'h07) begin
            n_fail++;
            $display("FAIL br_mask0_pc: pc=%h, want 07", PCOut);
        end
    endtask

    task automatic test_wrap_and_stall();
        fetch_word(16'h1EFF, 0, "br_toFF");
        advance_instr(3'b010, 0, "br_toFF");
        fetch_word(16'h3000, 5, "wrap");
        advance_instr(onehot_nzp(), 4, "wrap");
        n_checks++;
        if (PCOut !== 8'h00) begin
            n_fail++;
            $display("FAIL wrap_pc: pc=%h, want 00", PCOut);
        end
    endtask

    task automatic test_ret_restart();
        fetch_word(16'hF000, 0, "ret");
        advance_instr(onehot_nzp(), 0, "ret");
        // DONE holds; Advance and Ready are ignored there.
        Advance      = 1'b1;
        MemReadReady = 1'b1;
        MemReadData  = 16'h1234;
        tick();
        Advance      = 1'b0;
        MemReadReady = 1'b0;
        n_checks++;
        if (Done !== 1'b1 || Instr !== 16'hF000 || PCOut !== m_pc || MemReadValid !== 1'b0) begin
            n_fail++;
            $display("FAIL done_hold: done=%b instr=%h pc=%h mvalid=%b, want 1/F000/%h/0",
                     Done, Instr, PCOut, MemReadValid, m_pc);
        end
        restart("ret");
    endtask

    task automatic test_random();
        logic [15:0] w;
        logic [3:0]  op;
        for (int k = 0; k < 60; k++) begin
            case ($urandom_range(0, 9))
                0:       w = {4'hF, 12'($urandom)};
                1, 2, 3, 4: w = {4'h1, 12'($urandom)};
                default: begin
                    op = 4'($urandom_range(0, 14));
                    if (op == 4'h1) op = 4'h0;
                    w = {op, 12'($urandom)};
                end
            endcase
            fetch_word(w, $urandom_range(0, 3), "rand");
            advance_instr(onehot_nzp(), $urandom_range(0, 3), "rand");
            if (is_ret(w)) restart("rand");
        end
    endtask

    task automatic test_reset_midfetch();
        // Make sure we sit in FETCH with a nonzero Instr held.
        fetch_word(16'h2ABC, 0, "pre_rst");
        advance_instr(3'b001, 0, "pre_rst");
        @(posedge CLK);
        #3;
        RST = 1'b1;
        #1;
        n_checks++;
        if (MemReadValid !== 1'b0 || InstrValid !== 1'b0 || Done !== 1'b0 || PCOut !== 8'h00 || Instr !== 16'h0) begin
            n_fail++;
            $display("FAIL rst_async: mvalid=%b ivalid=%b done=%b pc=%h instr=%h, want all zero",
                     MemReadValid, InstrValid, Done, PCOut, Instr);
        end
        tick();
        RST          = 1'b0;
        MemReadReady = 1'b1;
        MemReadData  = 16'h5A5A;
        tick();
        MemReadReady = 1'b0;
        tick();
        n_checks++;
        if (Instr !== 16'h0 || InstrValid !== 1'b0 || MemReadValid !== 1'b0 || PCOut !== 8'h00) begin
            n_fail++;
            $display("FAIL rst_late_ready: instr=%h ivalid=%b mvalid=%b pc=%h, want 0000/0/0/00",
                     Instr, InstrValid, MemReadValid, PCOut);
        end
    endtask

    initial begin
        m_pc    = 8'h00;
        m_instr = 16'h0000;
        test_reset();
        test_basic_fetch();
        test_branch_taken();
        test_branch_not_taken();
        test_wrap_and_stall();
        test_ret_restart();
        test_random();
        test_reset_midfetch();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
Per-thread program counter and instruction fetcher. It feeds fetched instructions to decode and consumes the stored N,Z,P flags from the NZP flag register to resolve BRnzp branches. It issues valid/ready read requests to program memory, holds each instruction until the core sequencer advances it, then computes the next PC (sequential, branch-taken, or halt on RET).

Parameters:
PM_ADDR_BITS, 8, program memory address width and PC width
PM_DATA_BITS, 16, instruction width
START_PC, 8'h00, PC value loaded on Start

Ports:
CLK  in  1  clock, all state updates on rising edge
RST  in  1  asynchronous, active-high reset
Start  in  1  begin execution at START_PC; accepted in IDLE or DONE only
Advance  in  1  sequencer has consumed the held instruction; accepted in HOLD only
NZPIn  in  3  stored flags {N,Z,P} from the NZP flag register
MemReadValid  out  1  program memory read request
MemReadAddr  out  PM_ADDR_BITS  request address; equals PCOut
MemReadReady  in  1  memory response; data valid in the same cycle
MemReadData  in  PM_DATA_BITS  instruction word
Instr  out  PM_DATA_BITS  held instruction
InstrValid  out  1  Instr is valid (state HOLD)
PCOut  out  PM_ADDR_BITS  current PC
Done  out  1  thread has executed RET (state DONE)

Behaviour:
- Reset is asynchronous and active-high. While RST=1: state=IDLE, PCOut=0, Instr=0, MemReadValid=0, InstrValid=0, Done=0. Outputs change immediately on RST assertion, not at the next edge.
- The FSM has four states: IDLE, FETCH, HOLD, DONE. All outputs are registered or decoded from state only. There are no combinational paths from inputs to outputs.
- IDLE: MemReadValid=0. On Start=1: PC<=START_PC, go to FETCH.
- FETCH: MemReadValid=1 and MemReadAddr=PC, both held stable until MemReadReady.
  - On MemReadReady=1: Instr<=MemReadData, go to HOLD. MemReadValid deasserts on the next cycle.
  - Minimum latency from entering FETCH to InstrValid=1 is 1 cycle (Ready in the first FETCH cycle).
- HOLD: InstrValid=1 and Instr is stable. The unit waits indefinitely for Advance.
- On Advance=1 in HOLD, decode Instr[15:12]:
  - 4'b1111 (RET): go to DONE. PC is unchanged.
  - 4'b0001 (BRnzp): if (Instr[11:9] & NZPIn) != 0, PC<=Instr[7:0] (zero-extended or truncated to PM_ADDR_BITS). Otherwise PC<=PC+1. Go to FETCH.
  - Any other opcode: PC<=PC+1, go to FETCH.
  - NZPIn is sampled only in the Advance cycle.
- DONE: Done=1, MemReadValid=0, InstrValid=0, PC and Instr hold. Start=1 restarts: PC<=START_PC, Done<=0, go to FETCH.
- Arithmetic: PC+1 is modulo 2^PM_ADDR_BITS (for example 8'hFF -> 8'h00). A branch with nzp mask 000 is never taken. A mask of 111 is always taken, since the flag register always holds one flag set.
- Ignored inputs:
  - Start in FETCH or HOLD is ignored.
  - Advance outside HOLD is ignored.
  - MemReadReady outside FETCH is ignored, and Instr is not updated.
- Simultaneous events:
  - Start and Advance in the same cycle: only the one legal for the current state takes effect.
  - RST overrides everything.
- Reset mid-fetch: MemReadValid drops asynchronously. A late MemReadReady after reset release is ignored because the state is IDLE.

Test Plan:
1. Reset, then Start. Memory answers Ready one cycle after Valid, with the word at addr 0 = 16'h3000. Required: MemReadAddr=0, then Instr=16'h3000 with InstrValid=1. Advance then gives PCOut=1 and MemReadValid=1.
2. Branch taken: Instr=16'h1A14 (BRnzp mask 101, target 8'h14), NZPIn=3'b100, Advance. Required: PCOut=8'h14 and MemReadAddr=8'h14 in the next cycle.
3. Branch not taken: same instruction at PC=5 with NZPIn=3'b010. Required: PCOut=6. Also check mask 000 with any NZPIn: not taken.
4. Wrap and stall: PC=8'hFF, non-branch instruction, Advance. Required: PCOut=8'h00.
   - Hold MemReadReady=0 for 5 cycles. Required: MemReadValid and MemReadAddr stable throughout.
   - Hold Advance=0 in HOLD for 4 cycles. Required: Instr unchanged.
5. RET: Instr=16'hF000, Advance. Required: Done=1 the next cycle, MemReadValid=0, PC unchanged. Then Start. Required: Done=0, PCOut=START_PC, FETCH issued.
6. Assert RST mid-FETCH, between clock edges. Required: MemReadValid=0 and state IDLE immediately. A Ready pulse after release is ignored, and Instr stays 0.
